// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter. It drives open-drain enables
// through the inhibit and request phases, shifts the byte out on the device's clock, and checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES     = 10000,
  parameter int REQ_SETUP_CYCLES   = 2000,
  parameter int FIRST_EDGE_TIMEOUT = 1500000,
  parameter int PACKET_TIMEOUT     = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);
  localparam int M0 = (INHIBIT_CYCLES > REQ_SETUP_CYCLES) ? INHIBIT_CYCLES : REQ_SETUP_CYCLES;
  localparam int M1 = (FIRST_EDGE_TIMEOUT > PACKET_TIMEOUT) ? FIRST_EDGE_TIMEOUT : PACKET_TIMEOUT;
  localparam int CW = $clog2(((M0 > M1) ? M0 : M1) + 1);
  localparam logic [CW-1:0] C_INH = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] C_REQ = CW'(REQ_SETUP_CYCLES - 1);
  localparam logic [CW-1:0] C_FE  = CW'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [CW-1:0] C_PKT = CW'(PACKET_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_WAIT_EDGE, S_SHIFT, S_WAIT_IDLE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_n;
  logic [7:0]      r_data;
  logic            r_par;
  logic            r_clk_s1, r_clk_s2, r_clk_s3, r_dat_s1, r_dat_s2;
  logic            w_fall, w_abort;
  logic [CW-1:0]   w_cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_clk_s1, r_clk_s2, r_clk_s3, r_dat_s1, r_dat_s2} <= '1;
    end else begin
      {r_clk_s3, r_clk_s2, r_clk_s1} <= {r_clk_s2, r_clk_s1, ps2_clk_in};
      {r_dat_s2, r_dat_s1} <= {r_dat_s1, ps2_data_in};
    end
  end

  always_comb begin
    w_fall    = r_clk_s3 & ~r_clk_s2;
    w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    w_abort   = (r_state == S_WAIT_EDGE) ? (!w_fall && r_cnt == C_FE) :
                (r_state == S_SHIFT || r_state == S_WAIT_IDLE) ? (r_cnt == C_PKT) : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_n         <= '0;
      r_data      <= '0;
      r_par       <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_timeout <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      r_cnt       <= w_cnt_inc;
      if (w_abort) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        err_timeout <= 1'b1;
        busy        <= 1'b0;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            tx_ready <= 1'b1;
            if (tx_valid && tx_ready) begin
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              ps2_clk_oe <= 1'b1;
              ack_ok     <= 1'b0;
              r_data     <= tx_data;
              r_par      <= ~^tx_data;
              r_cnt      <= '0;
              r_n        <= '0;
              r_state    <= S_INHIBIT;
            end
          end
          S_INHIBIT: if (r_cnt == C_INH) begin
            ps2_data_oe <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_REQ;
          end
          S_REQ: if (r_cnt == C_REQ) begin
            ps2_clk_oe <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_WAIT_EDGE;
          end
          // the packet timeout is measured from this first falling edge
          S_WAIT_EDGE: if (w_fall) begin
            ps2_data_oe <= ~r_data[0];
            r_n         <= 4'd1;
            r_cnt       <= '0;
            r_state     <= S_SHIFT;
          end
          S_SHIFT: if (w_fall) begin
            r_n         <= r_n + 4'd1;
            ps2_data_oe <= (r_n < 4'd8) ? ~r_data[r_n[2:0]] : (r_n == 4'd8) ? ~r_par : 1'b0;
            if (r_n == 4'd10) begin
              ack_ok  <= ~r_dat_s2;
              r_state <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: if (r_clk_s2 && r_dat_s2) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 device model plus a scoreboard checking frames, ack status,
// line timing and timeouts of ps2_host_tx.
module tb_ps2_host_tx;
  localparam int INH = 20, REQ = 10, FE = 500, PKT = 2000, LAG = 3, H = 15;

  logic       clk = 0, rst = 1;
  logic [7:0] tx_data = 0;
  logic       tx_valid = 0;
  logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_ok, err_timeout;
  logic       dev_clk = 1, dev_data = 1;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_SETUP_CYCLES(REQ), .FIRST_EDGE_TIMEOUT(FE),
                .PACKET_TIMEOUT(PKT)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .ack_ok(ack_ok),
    .err_timeout(err_timeout));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {M_ACK, M_NACK, M_NOCLK, M_STOP5} mode_t;
  typedef struct {bit tmo; bit ack; logic [10:0] frame; int dly; bit from_fall;} exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  mode_t       dev_mode = M_ACK;
  logic [10:0] dev_frame = '0;
  int          t_fall1 = 0, t_rel = 0, dev_edge = 0, run = 0;
  bit          dev_active = 0, prev_data_oe = 0, in_xfer = 0, gap = 0;
  int          checks = 0, passes = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: start 0, data LSB first, odd parity (1 when the byte has an even number of ones), stop 1.
  function automatic exp_t model(logic [7:0] b, mode_t m);
    exp_t e;
    e.frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) e.frame[i+1] = b[i];
    e.frame[9]  = ($countones(b) % 2 == 0);
    e.frame[10] = 1'b1;
    e.tmo       = (m == M_NOCLK || m == M_STOP5);
    e.ack       = (m == M_ACK);
    e.from_fall = (m == M_STOP5);
    e.dly       = (m == M_NOCLK) ? FE : LAG + PKT;
    return e;
  endfunction

  // Device model: clocks 11 falling edges, samples on rising edges, acks on the 11th.
  initial forever begin
    @(negedge clk);
    if (!rst && ps2_clk_in && !ps2_data_in) begin
      dev_active = 1;
      dev_edge = 0;
      dev_frame = '0;
      dev_frame[0] = ps2_data_in;
      if (dev_mode != M_NOCLK) begin
        repeat (4) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
          if (e == 11 && dev_mode == M_ACK) dev_data = 0;
          dev_clk = 0;
          dev_edge = e;
          if (e == 1) t_fall1 = cyc;
          repeat (H) @(negedge clk);
          dev_clk = 1;
          if (e <= 10) dev_frame[e] = ps2_data_in;
          if (dev_mode == M_STOP5 && e == 5) break;
          repeat (H) @(negedge clk);
        end
        dev_data = 1;
      end
      for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
      dev_active = 0;
    end
  end

  // Monitor: line timing, busy continuity, and scoreboard pops on done/err_timeout.
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      in_xfer = 0;
    end else begin
      if (ps2_clk_oe) begin
        if (ps2_data_oe && !prev_data_oe) check("req_start", run, INH);
        run++;
      end else if (run != 0) begin
        check("clk_low_len", run, INH + REQ);
        run = 0;
        t_rel = cyc;
      end
      if (in_xfer && !busy && !done && !err_timeout) gap = 1;
      if (done || err_timeout) begin
        check("busy_held", 32'(gap), 0);
        in_xfer = 0;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_end: done=%0b err_timeout=%0b with no transfer expected", done, err_timeout);
        end else begin
          m_e = sb.pop_front();
          check("end_kind", {done, err_timeout}, m_e.tmo ? 2'b01 : 2'b10);
          if (m_e.tmo) begin
            check("tmo_delay", cyc - (m_e.from_fall ? t_fall1 : t_rel), m_e.dly);
            check("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
          end else begin
            check("ack_ok", ack_ok, 32'(m_e.ack));
            check("frame", dev_frame, m_e.frame);
          end
        end
      end
      if (tx_valid && tx_ready) begin
        in_xfer = 1;
        gap = 0;
      end
    end
    prev_data_oe = ps2_data_oe;
  end

  task automatic wait_ready(string name);
    for (int i = 0; i < 20000 && !tx_ready; i++) begin @(posedge clk); #1; end
    check(name, tx_ready, 1);
  endtask

  task automatic wait_dev_idle();
    for (int i = 0; i < 5000 && dev_active; i++) begin @(posedge clk); #1; end
    check("dev_idle", 32'(dev_active), 0);
  endtask

  task automatic send(logic [7:0] b, mode_t m);
    wait_dev_idle();
    wait_ready("ready_before");
    dev_mode = m;
    sb.push_back(model(b, m));
    tx_data = b;
    tx_valid = 1;
    @(posedge clk); #1;
    tx_valid = 0;
    wait_ready("ready_after");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_timeout}, 0);
    rst = 0;
    @(posedge clk); #1;
    check("ready_after_rst", tx_ready, 1);

    send(8'hF4, M_ACK);
    send(8'h00, M_ACK);
    send(8'hFF, M_ACK);
    send(8'h01, M_ACK);
    send(8'hA5, M_NACK);
    send(8'h3C, M_NOCLK);
    send(8'hC3, M_STOP5);
    repeat (6) send(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK);

    // back-to-back with tx_valid held, then a pulse while busy that must be ignored
    wait_dev_idle();
    wait_ready("b2b_ready0");
    dev_mode = M_ACK;
    sb.push_back(model(8'hFF, M_ACK));
    sb.push_back(model(8'hF4, M_ACK));
    tx_data = 8'hFF;
    tx_valid = 1;
    @(posedge clk); #1;
    tx_data = 8'hF4;
    wait_ready("b2b_ready1");
    @(posedge clk); #1;
    tx_valid = 0;
    check("b2b_accept", tx_ready, 0);
    repeat (100) @(posedge clk); #1;
    tx_data = 8'h55;
    tx_valid = 1;
    repeat (3) @(posedge clk); #1;
    tx_valid = 0;
    check("busy_during_pulse", busy, 1);
    wait_ready("b2b_ready2");

    // reset in the middle of the shift phase
    wait_dev_idle();
    dev_mode = M_ACK;
    tx_data = 8'h00;
    tx_valid = 1;
    @(posedge clk); #1;
    tx_valid = 0;
    for (int i = 0; i < 5000 && !(dev_active && dev_edge >= 3); i++) begin @(posedge clk); #1; end
    check("pre_rst_data_oe", ps2_data_oe, 1);
    #2 rst = 1;
    #1 check("rst_async_oe", {ps2_clk_oe, ps2_data_oe, busy}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    check("ready_after_midrst", {tx_ready, busy}, 2'b10);
    send(8'hF4, M_ACK);

    repeat (50) @(posedge clk); #1;
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xF4 "enable data reporting", 0xFF "reset", 0xF3 "set sample rate") to the mouse on the shared PS2Clk/PS2Data open-drain lines. It is the transmit-direction counterpart of the PS/2 receive path that produces `xpos`/`ypos`. It runs in the 100 MHz domain. The top level turns its drive-low enables into open-drain pads: PS2Clk is 0 when `ps2_clk_oe` is 1, otherwise high-Z; PS2Data likewise.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 10000: clock-inhibit hold time, 100 µs at 100 MHz.
- `REQ_SETUP_CYCLES`, default 2000: time data is held low before clock is released, 20 µs.
- `FIRST_EDGE_TIMEOUT`, default 1500000: maximum wait for the device's first falling clock edge, 15 ms.
- `PACKET_TIMEOUT`, default 200000: maximum time from first falling edge to ack, 2 ms.

Ports:
- `clk` input 1: 100 MHz clock. One clock domain only.
- `rst` input 1: reset, asynchronous and active-high.
- `tx_data` input 8: command byte, sampled at accept.
- `tx_valid` input 1: send request.
- `tx_ready` output 1: block is idle and can accept a request.
- `ps2_clk_in` input 1: PS2Clk pad value, asynchronous.
- `ps2_data_in` input 1: PS2Data pad value, asynchronous.
- `ps2_clk_oe` output 1: 1 drives PS2Clk low.
- `ps2_data_oe` output 1: 1 drives PS2Data low.
- `busy` output 1: a transfer is in progress.
- `done` output 1: one-cycle pulse at the end of a transfer.
- `ack_ok` output 1: valid with `done`; 1 if the device acknowledged.
- `err_timeout` output 1: one-cycle pulse when a transfer is aborted by a timeout.

## Operation
Input conditioning:
- `ps2_clk_in` and `ps2_data_in` each pass through a 2-FF synchronizer.
- A falling-edge strobe `fall` is asserted when the synchronized clock goes 1→0, detected against a third register.

State machine:
- **IDLE**: `tx_ready`=1 and both oe=0. When `tx_valid`=1, latch `tx_data`, compute parity = ~^tx_data (odd parity), clear counters, go to INHIBIT.
- **INHIBIT**: `ps2_clk_oe`=1 for `INHIBIT_CYCLES`, then go to REQ.
- **REQ**: `ps2_clk_oe`=1 and `ps2_data_oe`=1 (start bit 0) for `REQ_SETUP_CYCLES`. Then release the clock (`ps2_clk_oe`=0) and go to WAIT_EDGE.
- **WAIT_EDGE**: keep `ps2_data_oe`=1. Go to SHIFT on the first `fall`. Abort if `FIRST_EDGE_TIMEOUT` cycles pass first.
- **SHIFT**: a 4-bit bit counter `n` counts falling edges 1..11.
  - Edges 1–8: drive data bit D[n-1], LSB first; `ps2_data_oe` = ~bit.
  - Edge 9: drive the parity bit.
  - Edge 10: release data (stop bit = 1).
  - Edge 11: sample synchronized data. 0 means ACK, 1 means NACK. Go to WAIT_IDLE.
- **WAIT_IDLE**: wait until synchronized clock=1 and data=1. Then pulse `done` with `ack_ok`=(ACK seen) and go to IDLE.
- `PACKET_TIMEOUT` counts from the first `fall`. It covers SHIFT and WAIT_IDLE.
- **Abort**: on any timeout, release both lines in the same cycle, pulse `err_timeout`, do not pulse `done`, and return to IDLE.
- `tx_valid` is ignored while `tx_ready`=0; there is no queuing.
- Counter widths are sized by `$clog2` of the largest parameter. Counters saturate and never wrap.

## Timing
Reset values:
- `ps2_clk_oe`=0, `ps2_data_oe`=0, `busy`=0, `done`=0, `ack_ok`=0, `err_timeout`=0.
- `tx_ready`=1 from the first cycle after `rst` deasserts.

Registering and handshake:
- All outputs are registered.
- Accept takes effect the cycle `tx_valid`&&`tx_ready`. On the next edge: `tx_ready`=0, `busy`=1, `ps2_clk_oe`=1.
- `busy` stays high until the cycle `done` or `err_timeout` pulses. `tx_ready` returns to 1 in the following cycle.

Line timing:
- `ps2_clk_oe` is low for exactly `INHIBIT_CYCLES` + `REQ_SETUP_CYCLES` cycles.
- `ps2_data_oe` rises at the INHIBIT→REQ transition.
- A data-line update lags the pad falling edge by 3 cycles (30 ns), far inside the 30–50 µs PS/2 half-period.

Reset and edge cases:
- **Reset mid-transfer**: both oe drop asynchronously, the state returns to IDLE, and no `done`/`err_timeout` pulse is produced.
- **Stray `fall`** in IDLE, INHIBIT or REQ: ignored.
- **NACK** (data=1 at edge 11): the transfer still completes with `done`=1, `ack_ok`=0.

## Test plan
Use a device-model bench with reduced parameters: INHIBIT=20, REQ=10, FIRST_EDGE=500, PACKET=2000.

1. **Reset**: assert `rst` mid-SHIFT → both oe=0 in the same cycle; after release, `tx_ready`=1; no pulses.
2. **Send 0xF4, model ACKs**:
   - Required: clk low for 30 cycles.
   - Sampled bits: 0 (start), 0,0,1,0,1,1,1,1, parity 0, stop 1.
   - Then one `done` pulse with `ack_ok`=1; `busy` high throughout.
3. **Parity**:
   - Send 0x00 → parity bit 1.
   - Send 0xFF → parity bit 1.
   - Send 0x01 → parity bit 0.
4. **NACK**: model leaves data high at edge 11 → `done`=1, `ack_ok`=0.
5. **Timeouts**:
   - Model never clocks → `err_timeout` pulse exactly 500 cycles after the clock is released; lines released; no `done`.
   - Model stops after edge 5 → `err_timeout` exactly 2000 cycles after edge 1.
6. **Back-to-back and ignored request**: hold `tx_valid`=1 with 0xFF then 0xF4 → the second byte is accepted only after `tx_ready` returns. `tx_valid` pulsed while busy is ignored.
